// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: drives one column at a time, senses active-low rows,
// debounces every key and publishes a row-major pressed bitmap.
module key_matrix_scanner #(
  parameter int N              = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [N-1:0]   rows_n,
  output logic [N-1:0]   cols,
  output logic [N*N-1:0] pressed,
  output logic           changed,
  output logic           frame_done
);

  localparam int K   = N * N;
  localparam int CIW = (N > 1) ? $clog2(N) : 1;
  localparam int SCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CIW-1:0] COL_LAST = CIW'(N - 1);
  localparam logic [SCW-1:0] CNT_LAST =
    SCW'(SETTLE_CYCLES - 1);
  localparam logic [DCW-1:0] DB_LAST =
    DCW'(DEBOUNCE_SCANS - 1);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("key_matrix_scanner: N must be 2..8");
  end
  if (SETTLE_CYCLES < 4) begin : g_bad_settle
    $error("key_matrix_scanner: SETTLE_CYCLES must be >= 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_db
    $error("key_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [0:0] {
    IDLE,
    DRIVE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CIW-1:0] col_q;
  logic [CIW-1:0] col_d;
  logic [SCW-1:0] cnt_q;
  logic [SCW-1:0] cnt_d;
  logic           sample;

  logic [N-1:0]   sync1;
  logic [N-1:0]   rows_sync;

  logic [DCW-1:0] db_q [K];
  logic [DCW-1:0] db_d [K];
  logic [K-1:0]   pressed_d;
  logic           any_flip;
  logic           raw_bit;

  // Two-flop synchronizer; idle (all ones) means no key closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '1;
      rows_sync <= '1;
    end else begin
      sync1     <= rows_n;
      rows_sync <= sync1;
    end
  end

  // Scan state register: state, column index, settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; sample marks the last settle cycle of a column.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        col_d = '0;
        cnt_d = '0;
        if (ena) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!ena) begin
          state_d = IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          sample = 1'b1;
          cnt_d  = '0;
          if (col_q == COL_LAST) begin
            col_d = '0;
          end else begin
            col_d = col_q + CIW'(1);
          end
        end else begin
          cnt_d = cnt_q + SCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Column drive decodes straight from state so reset clears it at once.
  always_comb begin
    cols = '0;
    if (state_q == DRIVE) begin
      cols[col_q] = 1'b1;
    end
  end

  // Per-key debounce, only for keys in the column being sampled.
  always_comb begin
    pressed_d = pressed;
    any_flip  = 1'b0;
    raw_bit   = 1'b0;
    for (int k = 0; k < K; k++) begin
      db_d[k] = db_q[k];
      if (sample && col_q == CIW'(k % N)) begin
        raw_bit = ~rows_sync[k / N];
        if (raw_bit == pressed[k]) begin
          db_d[k] = '0;
        end else if (db_q[k] == DB_LAST) begin
          pressed_d[k] = ~pressed[k];
          db_d[k]      = '0;
          any_flip     = 1'b1;
        end else begin
          db_d[k] = db_q[k] + DCW'(1);
        end
      end
    end
  end

  // Debounce state, key map and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed    <= '0;
      changed    <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < K; k++) begin
        db_q[k] <= '0;
      end
    end else begin
      pressed    <= pressed_d;
      changed    <= any_flip;
      frame_done <= sample && (col_q == COL_LAST);
      for (int k = 0; k < K; k++) begin
        db_q[k] <= db_d[k];
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner (N=8, settle 4, debounce 3).
// A behavioural key matrix closes rows for the columns being driven.
module tb_key_matrix_scanner;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [7:0]  rows_n;
  logic [7:0]  cols;
  logic [63:0] pressed;
  logic        changed;
  logic        frame_done;

  logic [63:0] keymap;
  int          cyc;
  int          errors;
  int          checks;

  localparam logic [63:0] K21 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] K3_59 = 64'h0800_0000_0000_0008;

  key_matrix_scanner #(
    .N(8),
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .rows_n(rows_n),
    .cols(cols),
    .pressed(pressed),
    .changed(changed),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive matrix: a row is pulled low by any closed key in a live column.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      rows_n[r] = ~|(cols & keymap[r*8 +: 8]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_cols(input int c);
    logic [7:0] one;
    one = 8'h01;
    return one << ((c / 4) % 8);
  endfunction

  function automatic logic exp_fd(input int c);
    return (c > 0) && (c % 32 == 0);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Advance to cycle target, checking every cycle strictly before it.
  task automatic run_to(input int target,
                        input logic [63:0] exp_p);
    while (cyc < target) begin
      tick();
      if (cyc < target) begin
        chk("cols", {56'd0, cols}, {56'd0, exp_cols(cyc)});
        chk("pressed", pressed, exp_p);
        chk("changed", {63'd0, changed}, 64'd0);
        chk("frame_done", {63'd0, frame_done},
            {63'd0, exp_fd(cyc)});
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    keymap = '0;
    rst    = 1'b1;
    ena    = 1'b1;

    // 1: reset holds everything idle even with ena high
    @(negedge clk);
    @(negedge clk);
    chk("rst_cols", {56'd0, cols}, 64'd0);
    chk("rst_pressed", pressed, 64'd0);
    chk("rst_changed", {63'd0, changed}, 64'd0);
    chk("rst_fd", {63'd0, frame_done}, 64'd0);
    rst = 1'b0;
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_cols", {56'd0, cols}, 64'd0);
    end

    // 2: free-running scan, no keys
    ena = 1'b1;
    cyc = -1;
    run_to(64, 64'd0);
    chk("fd64", {63'd0, frame_done}, 64'd1);
    chk("cols64", {56'd0, cols}, 64'h01);

    // 3: key r2c5 pressed then released
    keymap = K21;
    run_to(152, 64'd0);
    chk("k21_press", pressed, K21);
    chk("k21_chg", {63'd0, changed}, 64'd1);
    run_to(160, K21);
    keymap = '0;
    run_to(248, K21);
    chk("k21_release", pressed, 64'd0);
    chk("k21_rchg", {63'd0, changed}, 64'd1);
    run_to(256, 64'd0);

    // 4: bounce 2 on / 1 off / 2 on never flips
    keymap = K21;
    run_to(320, 64'd0);
    keymap = '0;
    run_to(352, 64'd0);
    keymap = K21;
    run_to(416, 64'd0);
    keymap = '0;
    run_to(448, 64'd0);

    // 5: two keys in column 3 flip on the same edge
    keymap = K3_59;
    run_to(528, 64'd0);
    chk("col3_press", pressed, K3_59);
    chk("col3_chg", {63'd0, changed}, 64'd1);
    run_to(560, K3_59);

    // 6: abort during column 4, restart, then async reset
    chk("abort_cols", {56'd0, cols}, 64'h10);
    ena = 1'b0;
    tick();
    chk("abort_off", {56'd0, cols}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      chk("abort_pressed", pressed, K3_59);
      chk("abort_fd", {63'd0, frame_done}, 64'd0);
      chk("abort_idle", {56'd0, cols}, 64'd0);
      tick();
    end
    ena = 1'b1;
    cyc = -1;
    run_to(4, K3_59);
    chk("restart_c1", {56'd0, cols}, 64'h02);
    run_to(10, K3_59);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cols", {56'd0, cols}, 64'd0);
    chk("arst_pressed", pressed, 64'd0);
    chk("arst_changed", {63'd0, changed}, 64'd0);
    chk("arst_fd", {63'd0, frame_done}, 64'd0);
    @(negedge clk);
    keymap = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cols", {56'd0, cols}, 64'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Reads a passive N×N push-button matrix that shares its wiring style with the LED array driver.
- Drives one column at a time (one-hot, active-high) and senses active-low rows through a synchronizer.
- Debounces each key and publishes a debounced N*N bitmap.
- Bitmap layout is identical to the LED driver's cells bus (bit r*N+c = row r, column c), so the map can feed the Conway grid or the LED driver directly.

Parameters:
- N, 8, matrix size; legal range 2..8; $error outside that range.
- SETTLE_CYCLES, 16, clock cycles each column is driven before sampling; must be >= 4; $error otherwise.
- DEBOUNCE_SCANS, 4, consecutive frames a key's raw state must differ from its debounced state before the debounced state flips; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  scan enable.
- rows_n  input  N  raw row sense from pins, pulled up; low = key closed in the currently driven column; asynchronous to clk.
- cols  output  N  one-hot column drive, active-high; all zero when idle.
- pressed  output  N*N  debounced key map; bit r*N+c = 1 means pressed.
- changed  output  1  one-cycle pulse when any pressed bit flips.
- frame_done  output  1  one-cycle pulse after column N-1 has been sampled.

Behaviour:
- Reset (async, rst=1): cols=0, pressed=0, changed=0, frame_done=0, column index=0, settle counter=0, all debounce counters=0, synchronizer flops=all ones (idle).
- Synchronizer: rows_n passes through 2 flops to give rows_sync. Logic uses only rows_sync. raw[r] = ~rows_sync[r].
- FSM states:
  - IDLE: cols=0; column index=0; settle counter=0. If ena=1 at a clock edge, go to DRIVE; cols=one-hot(0) from the next cycle.
  - DRIVE: cols=one-hot(column index) for exactly SETTLE_CYCLES consecutive cycles. The settle counter counts 0..SETTLE_CYCLES-1.
  - Sample edge: the edge ending the cycle where counter=SETTLE_CYCLES-1.
    - Capture raw[0..N-1] for column c.
    - Update debounce for keys r*N+c, for every r.
    - Advance column index; it wraps N-1 -> 0.
    - Reset the settle counter.
    - Stay in DRIVE. The next column is driven in the very next cycle; there is no gap cycle.
- Column period is SETTLE_CYCLES cycles; frame period is N*SETTLE_CYCLES cycles.
- Debounce per key (counter width $clog2(DEBOUNCE_SCANS+1)), evaluated only at that key's column sample edge:
  - If raw == pressed bit: counter <= 0.
  - Else if counter == DEBOUNCE_SCANS-1: toggle the pressed bit and set counter <= 0.
  - Else: counter <= counter+1.
  - Result: a flip needs DEBOUNCE_SCANS consecutive disagreeing samples of that key.
- changed: 1 in the cycle after a sample edge on which at least one pressed bit toggled; otherwise 0. Multiple toggles on the same edge give one pulse.
- frame_done: 1 in the cycle after the column N-1 sample edge. This is the same cycle cols shows one-hot(0) again.
- pressed updates on the sample edge, so it is valid in the same cycle as changed/frame_done.
- ena deasserted in any state: at the next edge go to IDLE, cols=0, column index=0, settle counter cleared. The partial column is discarded (no sample). pressed and debounce counters hold. No frame_done pulse.
- Re-enable always restarts at column 0 with a full settle period.
- Async reset mid-scan: all outputs clear immediately; the synchronizer reloads idle.
- Ghosting/masking from 3+ simultaneous keys is not corrected; raw values are taken as sensed.

Test Plan:
- Setup: N=8, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3. Bench matrix model: rows_n[r] = ~|(cols & keymap[r*8 +: 8]).
1. Reset/idle: assert rst with ena=1 -> cols=0x00, pressed=0, changed=0, frame_done=0. Release rst with ena=0 for 20 cycles -> cols stays 0x00.
2. Scan order: ena=1, no keys -> cols steps 0x01,0x02,...,0x80, each held exactly 4 cycles, repeating. frame_done pulses every 32 cycles, coinciding with cols=0x01. pressed=0; changed never asserts.
3. Single key r=2,c=5 (bit 21) held -> pressed[21]=1 and one changed pulse, in the cycle after column 5's sample edge of the 3rd frame. Release -> pressed[21]=0 after 3 further column-5 samples, with one changed pulse.
4. Bounce: bit 21 present for 2 frames, absent 1 frame, present 2 frames -> pressed stays 0; changed never asserts.
5. Same-column keys r0c3 and r7c3 (bits 3 and 59) held -> both bits set on the same edge; exactly one changed pulse.
6. Abort: drop ena while cols=0x10 -> cols=0x00 next cycle; pressed holds; no frame_done. Re-raise ena -> cols=0x01 for 4 full cycles. Then assert rst mid-frame -> pressed=0 and cols=0x00 immediately.
